reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register and data width in bits.
REQ-002 SHALL have parameter NREGS, default 4: number of registers; the register index is 2 bits wide.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port WR, input, 1 bit: write enable, active high.
REQ-006 SHALL have port rs, input, 2 bits: register select, used for both the write and the read.
REQ-007 SHALL have port data, input, DATA_W bits: write data.
REQ-008 SHALL have port regVal, output, DATA_W bits: contents of the selected register.

Function
REQ-009 SHALL hold NREGS independent DATA_W-bit registers, R0..R3.
REQ-010 SHALL, when WR=1 at a rising clk edge, load data into R[rs]; no other register changes.
REQ-011 SHALL, when WR=0 at a rising clk edge, leave all registers unchanged; data is ignored.
REQ-012 SHALL drive regVal combinationally from R[rs], with zero-cycle latency from a change on rs.
REQ-013 SHALL make a write visible on regVal immediately after the write edge if rs is unchanged (1-cycle write-to-read latency), unless REQ-020 applies.
REQ-014 SHALL treat every rs value 0..3 as valid; there is no out-of-range case.
REQ-015 SHALL keep regVal free of X once reset has been applied, for any rs.
REQ-016 SHALL, if WR=1 on consecutive edges to the same rs, retain only the last written value.

Reset
REQ-017 SHALL, while reset_n=0, immediately clear R0..R3 to 0 without waiting for clk; regVal then reads 0.
REQ-018 SHALL ignore WR while reset_n=0; a write edge coinciding with reset is lost.
REQ-019 SHALL accept writes from the first rising clk edge after reset_n goes high.

Configuration
REQ-020 SHALL support macro REG_BANK_BYPASS_EN: when defined, regVal = data whenever WR=1 (same-cycle write forwarding), and regVal = R[rs] otherwise; when undefined, regVal = R[rs] always and forwarding logic is absent.

Verification
REQ-021 SHALL pass this case: reset, then WR=1, rs=0, data=0x38, one clock -> regVal=0x38.
REQ-022 SHALL pass this case: after REQ-021, WR=0, rs=0, data=0x3F, one clock -> regVal stays 0x38.
REQ-023 SHALL pass this case: write 0x2B to R1, 0x23 to R2 and 0x03 to R3, each followed by one WR=0 clock carrying data 0xEB, 0xFB or 0xC3 respectively -> reading rs=1,2,3 returns 0x2B, 0x23, 0x03, and R0 still reads 0x38.
REQ-024 SHALL pass this case: assert reset_n=0 between clock edges -> regVal reads 0 immediately for all rs.
REQ-025 SHALL pass this case: WR=1, rs=2, data=0x55 before the edge -> regVal=0x55 before the edge with REG_BANK_BYPASS_EN defined, and the old R2 value without it.
REQ-026 SHALL pass this case: write 0xAA then 0x11 to R3 on back-to-back edges -> regVal=0x11 with rs=3.

Source files
------------

// File: rtl/reg_bank.sv
// Purpose: small bank of NREGS general registers, one shared select for write and read.
// Latency: read is combinational from rs; a write appears on regVal one edge later
// (same cycle when REG_BANK_BYPASS_EN is defined). Backpressure: none, a write is accepted every cycle.
module reg_bank #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              WR,
  input  logic [1:0]        rs,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] regVal
);

  // Register storage, R0..R(NREGS-1); every 2-bit select value addresses a real register.
  logic [DATA_W-1:0] regs [NREGS];

  // Asynchronous clear on reset; otherwise load data into the selected register when WR is high.
  // Registers that are not selected hold, and WR low leaves the whole bank untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WR) begin
      regs[rs] <= data;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  // Same-cycle forwarding: a pending write is visible on regVal before the edge commits it.
  always_comb begin
    regVal = regs[rs];
    if (WR) begin
      regVal = data;
    end
  end
`else
  // Plain read mux: regVal always reflects the stored contents of the selected register.
  always_comb begin
    regVal = regs[rs];
  end
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed table, reset corner cases, random traffic vs a model.
// Inputs change on the falling edge; outputs are sampled 1ns after changes or the rising edge.
// Works with or without REG_BANK_BYPASS_EN defined.
`timescale 1ns/1ps
module tb_reg_bank;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          WR;
  logic [1:0]    rs;
  logic [DW-1:0] data;
  logic [DW-1:0] regVal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the four register values as a plain array.
  logic [DW-1:0] model [4];

  typedef struct {
    logic          wr;
    logic [1:0]    sel;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [16];

  reg_bank #(.DATA_W(DW), .NREGS(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .WR     (WR),
    .rs     (rs),
    .data   (data),
    .regVal (regVal)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bypass_on();
`ifdef REG_BANK_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    r;
    logic [DW-1:0] exp;
    logic          w;
    logic [DW-1:0] d;

    WR = 1'b0; rs = 2'd0; data = '0; reset_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Directed table: each row is applied before a rising edge and checked after it.
    vecs[0]  = '{1'b1, 2'd0, 8'h38, 8'h38};
    vecs[1]  = '{1'b0, 2'd0, 8'h3F, 8'h38};
    vecs[2]  = '{1'b1, 2'd1, 8'h2B, 8'h2B};
    vecs[3]  = '{1'b0, 2'd1, 8'hEB, 8'h2B};
    vecs[4]  = '{1'b1, 2'd2, 8'h23, 8'h23};
    vecs[5]  = '{1'b0, 2'd2, 8'hFB, 8'h23};
    vecs[6]  = '{1'b1, 2'd3, 8'h03, 8'h03};
    vecs[7]  = '{1'b0, 2'd3, 8'hC3, 8'h03};
    vecs[8]  = '{1'b0, 2'd1, 8'h00, 8'h2B};
    vecs[9]  = '{1'b0, 2'd2, 8'h00, 8'h23};
    vecs[10] = '{1'b0, 2'd3, 8'h00, 8'h03};
    vecs[11] = '{1'b0, 2'd0, 8'hFF, 8'h38};
    vecs[12] = '{1'b1, 2'd3, 8'hAA, 8'hAA};
    vecs[13] = '{1'b1, 2'd3, 8'h11, 8'h11};
    vecs[14] = '{1'b0, 2'd3, 8'h99, 8'h11};
    vecs[15] = '{1'b0, 2'd0, 8'h00, 8'h38};

    // Initial reset, asserted between edges; every select must read zero.
    #2 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs = 2'(i);
      #1 check("reset_read", regVal, 8'h00);
    end
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      WR = vecs[i].wr; rs = vecs[i].sel; data = vecs[i].din;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), regVal, vecs[i].exp);
      if (vecs[i].wr) model[vecs[i].sel] = vecs[i].din;
    end

    // Same-cycle forwarding visible before the edge only when the bypass is built in.
    @(negedge clk);
    WR = 1'b1; rs = 2'd2; data = 8'h55;
    #1 check("bypass_pre_edge", regVal, bypass_on() ? 8'h55 : model[2]);
    @(posedge clk);
    #1 check("bypass_post_edge", regVal, 8'h55);
    model[2] = 8'h55;

    // Asynchronous reset between edges clears immediately, no clock needed.
    @(negedge clk);
    WR = 1'b0;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs = 2'(i);
      #1 check("async_reset_read", regVal, 8'h00);
    end
    for (int i = 0; i < 4; i++) model[i] = '0;

    // A write edge while reset is held is lost.
    @(negedge clk);
    WR = 1'b1; rs = 2'd1; data = 8'h77;
    @(posedge clk);
    #1 WR = 1'b0;
    #1 check("write_during_reset", regVal, 8'h00);

    // First edge after reset release accepts a write.
    @(negedge clk);
    reset_n = 1'b1;
    WR = 1'b1; rs = 2'd1; data = 8'h5A;
    @(posedge clk);
    #1 WR = 1'b0;
    #1 check("first_write_after_reset", regVal, 8'h5A);
    model[1] = 8'h5A;
    rs = 2'd0;
    #1 check("other_reg_after_reset", regVal, 8'h00);

    // Randomized traffic against the array model.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      w = 1'($urandom_range(0, 1));
      r = 2'($urandom_range(0, 3));
      d = DW'($urandom);
      WR = w; rs = r; data = d;
      #1 check("rand_pre_edge", regVal, (bypass_on() && w) ? d : model[r]);
      @(posedge clk);
      if (w) model[r] = d;
      #1 check("rand_post_edge", regVal, model[r]);
      WR = 1'b0;
      r = 2'($urandom_range(0, 3));
      rs = r;
      #1 check("rand_read", regVal, model[r]);
    end

    // Final sweep of all registers.
    @(negedge clk);
    WR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs = 2'(i);
      exp = model[i];
      #1 check("final_sweep", regVal, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
